mult_acc_frame: RTL

Frame accumulator downstream of the team's 4x4 unsigned combinational array multiplier. It consumes the 8-bit product stream through a valid/ready handshake and sums up to FRAME_LEN products per frame. It presents each frame sum, with its beat count, on a held valid/ready output port. It is the first sequential stage after the multiplier and supplies the dot-product/MAC path.

---
 rtl/mult_acc_pkg.sv | 22 ++
 rtl/acc_frame_ctrl.sv | 78 +++++++
 rtl/mult_acc_frame.sv | 88 ++++++++
 3 files changed

// File: rtl/mult_acc_pkg.sv
// mult_acc_pkg
// Shared types and constants for the frame accumulator that sits after the
// 4x4 unsigned array multiplier.
//   state_t    : frame controller states (collecting beats / result held)
//   PROD_W     : width of one product beat from the multiplier
//   acc_width  : accumulator width needed to sum frame_len worst-case products
package mult_acc_pkg;

  typedef enum logic {
    ST_ACC,
    ST_OUT
  } state_t;

  localparam int PROD_W = 8;

  // Each product is at most 15*15 = 225 < 2**PROD_W, so frame_len of them
  // fit in PROD_W + clog2(frame_len) bits.
  function automatic int acc_width(input int frame_len);
    return PROD_W + $clog2(frame_len);
  endfunction

endpackage

// File: rtl/acc_frame_ctrl.sv
// acc_frame_ctrl
// Frame controller: owns the two-state FSM and the beat counter, and tells
// the datapath when a beat is taken, whether it starts or closes a frame.
// Ports:
//   clk, rst       : clock, asynchronous active-high reset
//   p_valid        : product beat offered
//   p_last         : offered beat ends the frame early
//   sum_ready      : consumer takes the held result
//   p_ready        : beat can be accepted this cycle (combinational)
//   beat           : beat handshake this cycle
//   close          : accepted beat closes the frame
//   first          : accepted beat is the first of its frame
//   sum_valid      : result held (registered, straight from state)
//   beats_next     : beat count including the current beat
module acc_frame_ctrl
  import mult_acc_pkg::*;
#(
  parameter int FRAME_LEN = 16,
  parameter int CNT_W     = $clog2(FRAME_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             p_valid,
  input  logic             p_last,
  input  logic             sum_ready,
  output logic             p_ready,
  output logic             beat,
  output logic             close,
  output logic             first,
  output logic             sum_valid,
  output logic [CNT_W-1:0] beats_next
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // A held result only blocks new beats while the consumer is stalling;
  // accepting the result frees the slot in the same cycle so there is no
  // bubble at frame boundaries.
  always_comb begin
    p_ready    = (state_q == ST_ACC) | sum_ready;
    beat       = p_valid & p_ready;
    first      = beat & (cnt_q == '0);
    close      = beat & (p_last | (cnt_q == LAST_IDX));
    beats_next = cnt_q + CNT_W'(1);
    sum_valid  = (state_q == ST_OUT);
  end

  // Next state and counter. In OUT a beat can only arrive together with the
  // result handshake; if it also closes, a fresh result replaces the old one
  // and the FSM stays in OUT.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_ACC:  if (close) state_d = ST_OUT;
      ST_OUT:  if (sum_ready && !close) state_d = ST_ACC;
    endcase
    if (close) begin
      cnt_d = '0;
    end else if (beat) begin
      cnt_d = beats_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_ACC;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/mult_acc_frame.sv
// mult_acc_frame
// Sums up to FRAME_LEN product beats per frame and presents each frame sum
// with its beat count on a held valid/ready port.
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   p_valid/p_ready     : product beat handshake (p_ready combinational)
//   p                   : unsigned 8-bit product
//   p_last              : beat closes the frame early
//   sum_valid/sum_ready : result handshake
//   sum                 : frame sum (ACC_W bits)
//   sum_beats           : beats in the frame, 1..FRAME_LEN
module mult_acc_frame
  import mult_acc_pkg::*;
#(
  parameter  int FRAME_LEN = 16,
  localparam int ACC_W     = acc_width(FRAME_LEN),
  localparam int CNT_W     = $clog2(FRAME_LEN + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p_valid,
  output logic              p_ready,
  input  logic [PROD_W-1:0] p,
  input  logic              p_last,
  output logic              sum_valid,
  input  logic              sum_ready,
  output logic [ACC_W-1:0]  sum,
  output logic [CNT_W-1:0]  sum_beats
);

  logic             beat, close, first;
  logic [CNT_W-1:0] beats_next;

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] sum_q, sum_d;
  logic [CNT_W-1:0] sum_beats_q, sum_beats_d;
  logic [ACC_W-1:0] acc_plus_p;

  acc_frame_ctrl #(
    .FRAME_LEN (FRAME_LEN),
    .CNT_W     (CNT_W)
  ) u_ctrl (
    .clk        (clk),
    .rst        (rst),
    .p_valid    (p_valid),
    .p_last     (p_last),
    .sum_ready  (sum_ready),
    .p_ready    (p_ready),
    .beat       (beat),
    .close      (close),
    .first      (first),
    .sum_valid  (sum_valid),
    .beats_next (beats_next)
  );

  // The first beat of a frame seeds the accumulator rather than adding to
  // it; the closing sum goes straight to the output register and the
  // accumulator is cleared for the next frame.
  always_comb begin
    acc_plus_p  = (first ? '0 : acc_q) + ACC_W'(p);
    acc_d       = acc_q;
    sum_d       = sum_q;
    sum_beats_d = sum_beats_q;
    if (close) begin
      sum_d       = acc_plus_p;
      sum_beats_d = beats_next;
      acc_d       = '0;
    end else if (beat) begin
      acc_d = acc_plus_p;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q       <= '0;
      sum_q       <= '0;
      sum_beats_q <= '0;
    end else begin
      acc_q       <= acc_d;
      sum_q       <= sum_d;
      sum_beats_q <= sum_beats_d;
    end
  end

  assign sum       = sum_q;
  assign sum_beats = sum_beats_q;

endmodule
